sram_burst_ctrl: RTL and testbench
==================================

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 32: width of the pipeline data word; a multiple of SRAM_DW.
REQ-002 SHALL have parameter SRAM_DW, default 16: SRAM data bus width.
REQ-003 SHALL have parameter ADDR_W, default 18: SRAM address width.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2: clock cycles per SRAM beat; must be >= 2.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port rd_en, input, 1: read request from the memory stage.
REQ-008 SHALL have port wr_en, input, 1: write request from the memory stage.
REQ-009 SHALL have port addr, input, ADDR_W: word address in WORD_W units.
REQ-010 SHALL have port wr_data, input, WORD_W: write data.
REQ-011 SHALL have port rd_data, output, WORD_W: registered read data.
REQ-012 SHALL have port ready, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port freeze, output, 1: pipeline stall request.
REQ-014 SHALL have ports SRAM_ADDR (output, ADDR_W), SRAM_DQ (inout, SRAM_DW), and SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N (outputs, 1, active-low).

Function
REQ-015 SHALL define BEATS = WORD_W/SRAM_DW and fail elaboration if WORD_W mod SRAM_DW != 0 or WAIT_CYCLES < 2.
REQ-016 SHALL implement FSM states IDLE, ACCESS and DONE, plus a beat counter (0..BEATS-1) and a wait counter (0..WAIT_CYCLES-1).
REQ-017 IDLE SHALL accept a request when rd_en or wr_en is high: latch addr, wr_data and op; clear both counters; go to ACCESS.
REQ-018 SHALL give wr_en priority when rd_en and wr_en are high together; the request is a write and rd_data is unchanged.
REQ-019 freeze SHALL be combinationally high in IDLE while a request is present, and high in every ACCESS cycle; it SHALL be low in DONE.
REQ-020 ACCESS SHALL occupy exactly BEATS*WAIT_CYCLES cycles; the wait counter increments each cycle and the beat counter increments when the wait counter wraps.
REQ-021 After the last cycle of the last beat, the FSM SHALL go to DONE for exactly one cycle with ready=1, then return to IDLE.
REQ-022 In DONE, rd_en and wr_en SHALL be ignored; a request still held is accepted only in the following IDLE cycle.
REQ-023 During ACCESS:
- SRAM_ADDR = (latched addr * BEATS + beat), truncated to ADDR_W (wrap-around, no error).
- SRAM_ADDR SHALL be 0 outside ACCESS.
REQ-024 During ACCESS, SRAM_CE_N, SRAM_UB_N and SRAM_LB_N SHALL be 0; outside ACCESS they SHALL be 1.
REQ-025 Reads SHALL drive SRAM_OE_N=0 throughout ACCESS; SRAM_DQ SHALL be high-Z.
REQ-026 Reads SHALL capture SRAM_DQ into rd_data[beat*SRAM_DW +: SRAM_DW] on the last cycle of each beat; beat 0 is the least-significant slice.
REQ-027 Writes SHALL drive SRAM_DQ with the wr_data slice for the current beat throughout ACCESS and keep SRAM_OE_N=1.
REQ-028 Writes SHALL hold SRAM_WE_N=0 on wait-counter values 0..WAIT_CYCLES-2 and SRAM_WE_N=1 on the last cycle of each beat (write recovery before the address changes).
REQ-029 rd_data SHALL hold its value until the next read completes.

Reset
REQ-030 SHALL, on rst=0 at any time including mid-ACCESS, immediately:
- force IDLE and clear both counters;
- set rd_data=0, ready=0, freeze=0, SRAM_ADDR=0;
- set all SRAM_*_N=1 and release SRAM_DQ to high-Z.
REQ-031 SHALL, after rst returns high, accept no request until the first rising edge.

Verification (WORD_W=32, SRAM_DW=16, ADDR_W=18, WAIT_CYCLES=2)
REQ-032 SHALL cover reset: rst=0 -> rd_data=0, freeze=0, ready=0, CE_N/WE_N/OE_N/UB_N/LB_N=1, DQ=Z.
REQ-033 SHALL cover a write: wr_en, addr=5, wr_data=32'hDEADBEEF -> SRAM[10]=16'hBEEF, SRAM[11]=16'hDEAD; freeze high for 5 cycles; ready pulses on cycle 5 after the request.
REQ-034 SHALL cover readback: rd_en, addr=5 -> rd_data=32'hDEADBEEF in the DONE cycle; OE_N=0 for exactly 4 cycles.
REQ-035 SHALL cover a held request: rd_en held through DONE -> exactly 4 CE_N-low cycles per access and one idle cycle between accesses; addr=18'h3FFFF -> SRAM_ADDR wraps to 18'h3FFFE then 18'h3FFFF.
REQ-036 SHALL cover mid-operation reset: rst=0 during beat 1 of a write -> CE_N=1, WE_N=1, DQ=Z and freeze=0 in the same cycle; SRAM[11] unchanged.
REQ-037 SHALL cover simultaneous requests: rd_en=wr_en=1, addr=7, wr_data=32'h12345678 -> write performed, SRAM[14]=16'h5678, SRAM[15]=16'h1234, rd_data unchanged.

Source files
------------

// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - multi-beat asynchronous SRAM access controller
// Splits one WORD_W pipeline access into BEATS SRAM beats of WAIT_CYCLES clocks each.
module sram_burst_ctrl #(
  parameter int WORD_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WORD_W-1:0]   wr_data,
  output logic [WORD_W-1:0]   rd_data,
  output logic                ready,
  output logic                freeze,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);

  localparam int BEATS = WORD_W / SRAM_DW;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WC_W  = $clog2(WAIT_CYCLES);
  localparam logic [BC_W-1:0]   LAST_BEAT = BC_W'(BEATS - 1);
  localparam logic [WC_W-1:0]   LAST_WAIT = WC_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BEATS_A   = ADDR_W'(BEATS);

  generate
    if ((WORD_W % SRAM_DW) != 0 || WAIT_CYCLES < 2) begin : g_bad_params
      $error("sram_burst_ctrl: WORD_W must be a multiple of SRAM_DW and WAIT_CYCLES >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state;
  logic [BC_W-1:0]     bc;
  logic [WC_W-1:0]     wc;
  logic                op_wr;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;

  logic                in_access;
  logic                dq_drive;
  logic [ADDR_W-1:0]   beat_addr;
  logic [SRAM_DW-1:0]  wr_slice;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bc      <= '0;
      wc      <= '0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en || wr_en) begin
            op_wr   <= wr_en;
            addr_q  <= addr;
            wdata_q <= wr_data;
            bc      <= '0;
            wc      <= '0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (wc == LAST_WAIT) begin
            // Read data is sampled at the end of the beat, after the full access time
            if (!op_wr) rd_data[int'(bc)*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
            wc <= '0;
            if (bc == LAST_BEAT) state <= DONE;
            else                 bc    <= bc + 1'b1;
          end else begin
            wc <= wc + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_access = (state == ACCESS);
  assign dq_drive  = in_access && op_wr;
  assign beat_addr = (addr_q * BEATS_A) + ADDR_W'(bc);
  assign wr_slice  = wdata_q[int'(bc)*SRAM_DW +: SRAM_DW];

  // rst gate keeps freeze low while reset holds the FSM, even if a request is present
  assign freeze    = rst && (in_access || ((state == IDLE) && (rd_en || wr_en)));
  assign ready     = (state == DONE);

  assign SRAM_ADDR = in_access ? beat_addr : '0;
  assign SRAM_CE_N = !in_access;
  assign SRAM_UB_N = !in_access;
  assign SRAM_LB_N = !in_access;
  assign SRAM_OE_N = !(in_access && !op_wr);
  // WE_N rises on the final cycle of each beat so data/address stay valid past the write edge
  assign SRAM_WE_N = !(dq_drive && (wc != LAST_WAIT));
  assign SRAM_DQ   = dq_drive ? wr_slice : 'z;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb/tb_sram_burst_ctrl.sv - directed table-driven bench for sram_burst_ctrl
module tb_sram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [17:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready, freeze;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

  logic [15:0] mem [0:262143];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_burst_ctrl #(.WORD_W(32), .SRAM_DW(16), .ADDR_W(18), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .freeze(freeze),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N)
  );

  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 'z;

  always @(posedge clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [17:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [17:0] lo_idx;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int cyc = 0;
    int fz = 0;
    int oe = 0;
    int ce = 0;
    int rdy_at = -1;
    logic [31:0] rd_at_done = '0;
    rd_en = v.rd; wr_en = v.wr; addr = v.a; wr_data = v.wd;
    while (rdy_at < 0 && cyc < 20) begin
      #3;
      if (freeze) fz++;
      if (!SRAM_OE_N) oe++;
      if (!SRAM_CE_N) ce++;
      if (ready) begin
        rdy_at = cyc;
        rd_at_done = rd_data;
        rd_en = 1'b0;
        wr_en = 1'b0;
      end
      step();
      cyc++;
    end
    chk($sformatf("v%0d_ready_cycle", idx), 64'(rdy_at), 64'd5);
    chk($sformatf("v%0d_freeze_cycles", idx), 64'(fz), 64'd5);
    chk($sformatf("v%0d_ce_cycles", idx), 64'(ce), 64'd4);
    chk($sformatf("v%0d_oe_cycles", idx), 64'(oe), (v.rd && !v.wr) ? 64'd4 : 64'd0);
    chk($sformatf("v%0d_rd_data", idx), 64'(rd_at_done), 64'(v.exp_rd));
    if (v.wr) begin
      chk($sformatf("v%0d_mem_lo", idx), 64'(mem[v.lo_idx]), 64'(v.exp_lo));
      chk($sformatf("v%0d_mem_hi", idx), 64'(mem[v.lo_idx + 18'd1]), 64'(v.exp_hi));
    end
  endtask

  initial begin
    logic        exp_ce  [12];
    logic [17:0] exp_a   [12];
    logic        exp_rdy [12];

    vecs[0] = '{rd:1'b0, wr:1'b1, a:18'd5, wd:32'hDEADBEEF, exp_rd:32'h0,
                lo_idx:18'd10, exp_lo:16'hBEEF, exp_hi:16'hDEAD};
    vecs[1] = '{rd:1'b1, wr:1'b0, a:18'd5, wd:32'h0, exp_rd:32'hDEADBEEF,
                lo_idx:18'd10, exp_lo:16'h0, exp_hi:16'h0};
    vecs[2] = '{rd:1'b1, wr:1'b1, a:18'd7, wd:32'h12345678, exp_rd:32'hDEADBEEF,
                lo_idx:18'd14, exp_lo:16'h5678, exp_hi:16'h1234};
    vecs[3] = '{rd:1'b0, wr:1'b1, a:18'h3FFFF, wd:32'hCAFEF00D, exp_rd:32'hDEADBEEF,
                lo_idx:18'h3FFFE, exp_lo:16'hF00D, exp_hi:16'hCAFE};
    vecs[4] = '{rd:1'b1, wr:1'b0, a:18'h3FFFF, wd:32'h0, exp_rd:32'hCAFEF00D,
                lo_idx:18'h3FFFE, exp_lo:16'h0, exp_hi:16'h0};

    exp_ce  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_a   = '{18'h0, 18'h3FFFE, 18'h3FFFE, 18'h3FFFF, 18'h3FFFF, 18'h0,
                18'h0, 18'h3FFFE, 18'h3FFFE, 18'h3FFFF, 18'h3FFFF, 18'h0};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with a request present: nothing may leak out
    rst = 1'b0; rd_en = 1'b1; wr_en = 1'b0; addr = 18'd5; wr_data = 32'h0;
    #3;
    chk("rst_rd_data", 64'(rd_data), 64'h0);
    chk("rst_freeze", 64'(freeze), 64'h0);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_strobes_n", 64'({SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}), 64'h1F);
    chk("rst_sram_addr", 64'(SRAM_ADDR), 64'h0);
    chk("rst_dq_drive", 64'(dut.dq_drive), 64'h0);
    step();
    chk("rst_held_ce_n", 64'(SRAM_CE_N), 64'h1);
    rst = 1'b1; rd_en = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_txn(i, vecs[i]);

    // Held read at the top address: one idle cycle between back-to-back accesses
    rd_en = 1'b1; addr = 18'h3FFFF;
    for (int c = 0; c < 12; c++) begin
      #3;
      chk($sformatf("hold_c%0d_ce_n", c), 64'(SRAM_CE_N), 64'(exp_ce[c]));
      chk($sformatf("hold_c%0d_addr", c), 64'(SRAM_ADDR), 64'(exp_a[c]));
      chk($sformatf("hold_c%0d_ready", c), 64'(ready), 64'(exp_rdy[c]));
      step();
    end
    rd_en = 1'b0;
    step();
    chk("hold_rd_data", 64'(rd_data), 64'hCAFEF00D);

    // Reset during beat 1 of a write to word 5
    wr_en = 1'b1; addr = 18'd5; wr_data = 32'h11112222;
    step();
    wr_en = 1'b0;
    step();
    step();
    #1;
    chk("midrst_pre_we_n", 64'(SRAM_WE_N), 64'h0);
    chk("midrst_pre_addr", 64'(SRAM_ADDR), 64'd11);
    rst = 1'b0;
    #1;
    chk("midrst_ce_n", 64'(SRAM_CE_N), 64'h1);
    chk("midrst_we_n", 64'(SRAM_WE_N), 64'h1);
    chk("midrst_dq_drive", 64'(dut.dq_drive), 64'h0);
    chk("midrst_freeze", 64'(freeze), 64'h0);
    chk("midrst_rd_data", 64'(rd_data), 64'h0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_mem10", 64'(mem[10]), 64'h2222);
    chk("midrst_mem11", 64'(mem[11]), 64'hDEAD);
    chk("midrst_idle_ce_n", 64'(SRAM_CE_N), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
